// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: r1 - r2 - bi, one bit per clock LSB first, start/ready/done handshake.
// Optional build macro SUBTRACTOR_SERIAL_SAT_EN saturates a borrowing result to zero.
module subtractor_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bi,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_br;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bnext;
  logic [WIDTH-1:0] w_shifted;

  assign w_accept  = start && (r_state != StShift);
  assign w_last    = (r_state == StShift) && (r_cnt == CntW'(WIDTH - 1));
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_bnext   = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_shifted = {w_d, r_result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = w_accept ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a   <= r1;
      r_b   <= r2;
      r_br  <= bi;
      r_cnt <= '0;
    end else if (r_state == StShift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bnext;
      r_cnt <= r_cnt + CntW'(1);
`ifdef SUBTRACTOR_SERIAL_SAT_EN
      r_result <= (w_last && w_bnext) ? '0 : w_shifted;
`else
      r_result <= w_shifted;
`endif
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign ready  = (r_state != StShift);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign borrow = r_br;

endmodule

// File: doc/subtractor_serial.md
# subtractor_serial

Bit-serial two's-complement subtractor, the inverse-direction companion to the team's ripple-carry adder datapath. It computes `r1 - r2 - bi` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It uses a start/ready/done handshake, which lets area-constrained datapaths share one subtract cell instead of instantiating WIDTH ripple cells. It sits beside the adder in the arithmetic unit and presents the same operand and result widths.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range is 2 to 32.
- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a subtraction; sampled only while `ready`=1.
- `r1` input, WIDTH bits: minuend; latched on an accepted `start`.
- `r2` input, WIDTH bits: subtrahend; latched on an accepted `start`.
- `bi` input, 1 bit: borrow in; latched on an accepted `start`.
- `ready` output, 1 bit: the block can accept `start`.
- `done` output, 1 bit: one-cycle pulse; `result` and `borrow` are valid from this cycle onward.
- `result` output, WIDTH bits: difference modulo 2^WIDTH.
- `borrow` output, 1 bit: borrow out of the MSB (1 means `r1 < r2 + bi` as unsigned values).

## Operation
- States:
  - IDLE: `ready`=1.
  - SHIFT: `ready`=0.
  - DONE: `ready`=1 and `done`=1.
- IDLE with `start`=1:
  - latch `r1`, `r2` and `bi` into the operand shift registers and the borrow flop;
  - clear the bit counter;
  - go to SHIFT.
- SHIFT, each cycle, using operand bits a and b and the borrow flop br:
  - difference bit d = a ^ b ^ br;
  - next borrow = (~a & b) | (~a & br) | (b & br);
  - shift d into the `result` register from the MSB side (shift right);
  - shift both operand registers right by one;
  - increment the counter.
- After the WIDTH-th SHIFT cycle, go to DONE.
- DONE lasts one cycle. It returns to IDLE, or, if `start`=1 in that cycle, accepts the new operands and goes straight to SHIFT (back-to-back operation).
- `result` and `borrow` hold their last computed values through IDLE until the next accepted `start`. `result` shifts visibly during SHIFT; its value is defined only at and after `done`.
- `start` while in SHIFT is ignored: no latch, no error.
- Operand inputs are don't-care outside the cycle in which `start` is accepted.
- Arithmetic is pure unsigned modulo 2^WIDTH with borrow out. No sign or overflow flag.

## Timing
- Reset values: state = IDLE, `ready`=1, `done`=0, `result`=0, `borrow`=0, counter=0, operand registers=0.
- Reset asserted mid-operation aborts the computation at the next edge. No `done` is produced, and all outputs take their reset values.
- Latency: `start` is accepted at edge k, SHIFT occupies edges k+1 through k+WIDTH, and `done`=1 in the cycle following edge k+WIDTH. That is, `done` rises WIDTH+1 cycles after the accepted `start`.
- Throughput: one result every WIDTH+1 cycles with `start` held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `SUBTRACTOR_SERIAL_SAT_EN` defined: on the transition into DONE, if the final borrow is 1, `result` is forced to 0 (unsigned saturation at zero). `borrow` still reports 1.
- `SUBTRACTOR_SERIAL_SAT_EN` undefined: `result` is the raw modulo-2^WIDTH difference.
- Latency and handshake are identical in both builds.

## Test plan
All scenarios use WIDTH=4.
- r1=10, r2=2, bi=0, `start` pulse -> `done` 5 cycles later with `result`=8, `borrow`=0, and `ready` back to 1.
- r1=10, r2=2, bi=1 -> `result`=7, `borrow`=0.
- r1=2, r2=10, bi=0 -> `result`=8 (0x8), `borrow`=1. With `SUBTRACTOR_SERIAL_SAT_EN` defined: `result`=0, `borrow`=1.
- r1=0, r2=0, bi=1 -> `result`=0xF, `borrow`=1. Follow with `start` held high and new operands r1=15, r2=15, bi=0 presented during the DONE cycle -> second `done` 5 cycles later with `result`=0, `borrow`=0.
- Issue r1=9, r2=3, then pulse `start` with r1=1, r2=1 two cycles later -> the second request is ignored and the result is 6, `borrow`=0.
- Assert `reset` for 1 cycle at the 2nd SHIFT cycle -> no `done` pulse, `result`=0, `borrow`=0, `ready`=1 on the next cycle. A subsequent 5-3 then yields 2.
